// File: rtl/shift_reg32_ctrl_pkg.sv
// Shared encodings for the 32-bit shift register sequencer: command ops,
// register mode codes, FSM states and the captured-command record.
package shift_reg32_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CON_HOLD  = 2'b00,
    CON_RIGHT = 2'b01,
    CON_LEFT  = 2'b10,
    CON_LOAD  = 2'b11
  } con_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic is_shift(op_e op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/shift_reg32_ctrl_if.sv
// Command channel (valid/ready) between a bus-side source and the sequencer.
// With SHIFT_CTRL_ROTATE_EN defined the channel also carries cmd_rot.
interface shift_reg32_ctrl_if #(
  parameter int CNT_W = 6
);
  import shift_reg32_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [CNT_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
`ifdef SHIFT_CTRL_ROTATE_EN
  logic              cmd_rot;

  modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, cmd_rot, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_len, cmd_data, cmd_rot, output cmd_ready);
`else
  modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_len, cmd_data, output cmd_ready);
`endif

endinterface

// File: rtl/shift_reg32_ctrl_cnt.sv
// Shift-length down-counter: loads the effective length (0 and >32 mean 32)
// and flags the final shift cycle when it reaches 1.
module shift_ctrl_cnt
  import shift_reg32_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             dec_i,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ((len_i == '0) || (len_i > FULL)) ? FULL : len_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_reg32_ctrl.sv
// Command-driven sequencer for a 32-bit shift register (hold/right/left/load).
// Optional rotate mode is enabled by defining SHIFT_CTRL_ROTATE_EN.
module shift_reg32_ctrl
  import shift_reg32_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  shift_reg32_ctrl_if.slave   cmd,
  input  logic                ser_in,
  output logic                ser_out,
  output logic                ser_out_valid,
  output logic [1:0]          sr_con,
  output logic                sr_sin,
  output logic [DATA_W-1:0]   sr_pi,
  input  logic [DATA_W-1:0]   sr_po,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ready;
  logic              accept;
  logic              last_shift;
`ifdef SHIFT_CTRL_ROTATE_EN
  logic              rot_q, rot_d;
`endif

  assign accept        = cmd.cmd_valid && ready;
  assign cmd.cmd_ready = ready;
  assign result        = result_q;

  shift_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept && is_shift(cmd.cmd_op)),
    .len_i  (cmd.cmd_len),
    .dec_i  (state_q == SHIFT),
    .last_o (last_shift)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_READ: state_d = DONE;
            OP_LOAD: state_d = LOAD;
            default: state_d = SHIFT;
          endcase
        end
      end
      LOAD:    state_d = DONE;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The register shifts whatever sits on sr_pi, so SHIFT feeds sr_po straight back.
  always_comb begin
    ready         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    sr_con        = CON_HOLD;
    sr_sin        = 1'b0;
    sr_pi         = '0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      LOAD: begin
        sr_con = CON_LOAD;
        sr_pi  = cmd_q.data;
      end
      SHIFT: begin
        sr_pi         = sr_po;
        ser_out_valid = 1'b1;
        if (cmd_q.op == OP_SHL) begin
          sr_con  = CON_LEFT;
          ser_out = sr_po[DATA_W-1];
        end else begin
          sr_con  = CON_RIGHT;
          ser_out = sr_po[0];
        end
`ifdef SHIFT_CTRL_ROTATE_EN
        sr_sin = rot_q ? ser_out : ser_in;
`else
        sr_sin = ser_in;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cmd_d    = cmd_q;
    result_d = result_q;
    if (accept) begin
      cmd_d.op   = cmd.cmd_op;
      cmd_d.data = cmd.cmd_data;
    end
    if (state_q == DONE) begin
      result_d = sr_po;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      result_q <= '0;
    end else begin
      cmd_q    <= cmd_d;
      result_q <= result_d;
    end
  end

`ifdef SHIFT_CTRL_ROTATE_EN
  assign rot_d = accept ? cmd.cmd_rot : rot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rot_q <= 1'b0;
    end else begin
      rot_q <= rot_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg32_ctrl.sv
// Self-checking bench: sequencer paired with a 32-bit shift register model;
// expected ser_out bits and results are queued at issue and popped on output.
module tb_shift_reg32_ctrl;
  import shift_reg32_ctrl_pkg::*;

  localparam int CNT_W = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_in, ser_out, ser_out_valid, sr_sin, busy, done;
  logic [1:0]  sr_con;
  logic [31:0] sr_pi, sr_po, result, sr_q;

  int asserts = 0;
  int fails   = 0;

  logic [31:0] model_val;
  bit          exp_bits[$];
  logic [31:0] exp_res[$];

  always #5 clk = ~clk;

  shift_reg32_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

  shift_reg32_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if),
    .ser_in        (ser_in),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .sr_con        (sr_con),
    .sr_sin        (sr_sin),
    .sr_pi         (sr_pi),
    .sr_po         (sr_po),
    .busy          (busy),
    .done          (done),
    .result        (result)
  );

  // Shift register model driven by the sequencer.
  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else begin
      case (sr_con)
        2'b01:   sr_q <= {sr_sin, sr_pi[31:1]};
        2'b10:   sr_q <= {sr_pi[30:0], sr_sin};
        2'b11:   sr_q <= sr_pi;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_po = sr_q;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the reference model for one command and queue expectations.
  task automatic model_cmd(input op_e op, input logic [CNT_W-1:0] len, input logic [31:0] data,
                           input logic sin, input logic rot, output int n, output int exp_done);
    bit b;
    n = 0;
    case (op)
      OP_LOAD: begin model_val = data; exp_done = 2; end
      OP_READ: exp_done = 1;
      default: begin
        n = ((len == 0) || (len > 32)) ? 32 : int'(len);
        for (int i = 0; i < n; i++) begin
          if (op == OP_SHR) begin
            b = model_val[0];
            model_val = {(rot ? b : sin), model_val[31:1]};
          end else begin
            b = model_val[31];
            model_val = {model_val[30:0], (rot ? b : sin)};
          end
          exp_bits.push_back(b);
        end
        exp_done = n + 1;
      end
    endcase
    exp_res.push_back(model_val);
  endtask

  task automatic drive_cmd(input op_e op, input logic [CNT_W-1:0] len, input logic [31:0] data,
                           input logic sin, input logic rot);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = len;
    cmd_if.cmd_data  = data;
    ser_in           = sin;
`ifdef SHIFT_CTRL_ROTATE_EN
    cmd_if.cmd_rot   = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
  endtask

  task automatic run_cmd(input op_e op, input logic [CNT_W-1:0] len, input logic [31:0] data,
                         input logic sin, input logic rot, input string name);
    int n, exp_done, shifts;
    bit seen_done, b;
    logic [31:0] r;
    model_cmd(op, len, data, sin, rot, n, exp_done);
    @(negedge clk);
    asserts++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready_before: got %b want 1", name, cmd_if.cmd_ready);
    end
    drive_cmd(op, len, data, sin, rot);
    seen_done = 0;
    shifts    = 0;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_if.cmd_valid = 1'b0;
        asserts++;
        if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
          fails++; $display("FAIL %s busy_t1: busy=%b ready=%b want 1/0", name, busy, cmd_if.cmd_ready);
        end
        if (op == OP_LOAD) begin
          asserts++;
          if (sr_con !== 2'b11 || sr_pi !== data) begin
            fails++; $display("FAIL %s load_drive: sr_con=%b sr_pi=%h want 11/%h", name, sr_con, sr_pi, data);
          end
        end
      end
      if (ser_out_valid === 1'b1) begin
        shifts++;
        asserts++;
        if (exp_bits.size() == 0) begin
          fails++; $display("FAIL %s ser_out_extra: unexpected shift cycle %0d", name, c);
        end else begin
          b = exp_bits.pop_front();
          if (ser_out !== b) begin
            fails++; $display("FAIL %s ser_out[%0d]: got %b want %b", name, c, ser_out, b);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        asserts++;
        if (c != exp_done) begin
          fails++; $display("FAIL %s done_cycle: got T+%0d want T+%0d", name, c, exp_done);
        end
      end
    end
    asserts++;
    if (!seen_done) begin
      fails++; $display("FAIL %s done_timeout: no done within 40 cycles", name);
    end
    asserts++;
    if (shifts != n) begin
      fails++; $display("FAIL %s shift_count: got %0d want %0d", name, shifts, n);
    end
    @(negedge clk);
    r = exp_res.pop_front();
    asserts++;
    if (result !== r) begin
      fails++; $display("FAIL %s result: got %h want %h", name, result, r);
    end
    asserts++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL %s idle_after: ready=%b busy=%b done=%b want 1/0/0",
                        name, cmd_if.cmd_ready, busy, done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ser_in = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = OP_READ;
    cmd_if.cmd_len = '0;
    cmd_if.cmd_data = '0;
`ifdef SHIFT_CTRL_ROTATE_EN
    cmd_if.cmd_rot = 1'b0;
`endif
    repeat (3) @(negedge clk);
    asserts++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: ready=%b busy=%b done=%b want 1/0/0", cmd_if.cmd_ready, busy, done);
    end
    asserts++;
    if (ser_out !== 1'b0 || ser_out_valid !== 1'b0 || sr_sin !== 1'b0) begin
      fails++; $display("FAIL reset_serial: ser_out=%b valid=%b sr_sin=%b want 0/0/0", ser_out, ser_out_valid, sr_sin);
    end
    asserts++;
    if (sr_con !== 2'b00 || sr_pi !== 32'h0 || result !== 32'h0) begin
      fails++; $display("FAIL reset_data: sr_con=%b sr_pi=%h result=%h want 00/0/0", sr_con, sr_pi, result);
    end
    reset = 1'b0;
    ser_in = 1'b0;
    model_val = '0;
  endtask

  task automatic test_load;
    run_cmd(OP_LOAD, 6'd0, 32'hA5A5_0F0F, 1'b0, 1'b0, "load");
    asserts++;
    if (result !== 32'hA5A5_0F0F) begin
      fails++; $display("FAIL load_const: got %h want a5a50f0f", result);
    end
    run_cmd(OP_READ, 6'd0, 32'h0, 1'b0, 1'b0, "read");
  endtask

  task automatic test_shr;
    run_cmd(OP_LOAD, 6'd0, 32'h8000_0001, 1'b0, 1'b0, "shr_load");
    run_cmd(OP_SHR, 6'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, "shr4");
    asserts++;
    if (result !== 32'hF800_0000) begin
      fails++; $display("FAIL shr4_const: got %h want f8000000", result);
    end
    run_cmd(OP_SHR, 6'd1, 32'h0, 1'b0, 1'b0, "shr1");
  endtask

  task automatic test_shl32;
    run_cmd(OP_LOAD, 6'd0, 32'h8000_0001, 1'b0, 1'b0, "shl_load");
    run_cmd(OP_SHL, 6'd0, 32'h0, 1'b0, 1'b0, "shl32");
    asserts++;
    if (result !== 32'h0000_0000) begin
      fails++; $display("FAIL shl32_const: got %h want 00000000", result);
    end
  endtask

  task automatic test_saturate;
    run_cmd(OP_LOAD, 6'd0, 32'h1234_5678, 1'b0, 1'b0, "sat_load");
    run_cmd(OP_SHL, 6'd33, 32'h0, 1'b1, 1'b0, "shl33");
    run_cmd(OP_LOAD, 6'd0, 32'hC3C3_5A5A, 1'b0, 1'b0, "sat_load2");
    run_cmd(OP_SHR, 6'd63, 32'h0, 1'b0, 1'b0, "shr63");
  endtask

  task automatic test_back_to_back;
    int n, ed;
    bit b;
    logic [31:0] r;
    run_cmd(OP_LOAD, 6'd0, 32'h1234_5678, 1'b0, 1'b0, "b2b_load");
    model_cmd(OP_SHL, 6'd3, 32'h0, 1'b1, 1'b0, n, ed);
    model_cmd(OP_READ, 6'd0, 32'h0, 1'b1, 1'b0, n, ed);
    @(negedge clk);
    drive_cmd(OP_SHL, 6'd3, 32'h0, 1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) cmd_if.cmd_op = OP_READ;
      if (c <= 4) begin
        asserts++;
        if (cmd_if.cmd_ready !== 1'b0) begin
          fails++; $display("FAIL b2b_ready_low[T+%0d]: got %b want 0", c, cmd_if.cmd_ready);
        end
      end
      if (c <= 3) begin
        asserts++;
        b = exp_bits.pop_front();
        if (ser_out_valid !== 1'b1 || ser_out !== b) begin
          fails++; $display("FAIL b2b_ser_out[T+%0d]: valid=%b bit=%b want 1/%b", c, ser_out_valid, ser_out, b);
        end
      end
      if (c == 4 || c == 6) begin
        asserts++;
        if (done !== 1'b1) begin
          fails++; $display("FAIL b2b_done[T+%0d]: got %b want 1", c, done);
        end
      end
      if (c == 5) begin
        r = exp_res.pop_front();
        asserts++;
        if (cmd_if.cmd_ready !== 1'b1 || done !== 1'b0 || result !== r) begin
          fails++; $display("FAIL b2b_accept2: ready=%b done=%b result=%h want 1/0/%h",
                            cmd_if.cmd_ready, done, result, r);
        end
      end
      if (c == 6) cmd_if.cmd_valid = 1'b0;
      if (c == 7) begin
        r = exp_res.pop_front();
        asserts++;
        if (result !== r || cmd_if.cmd_ready !== 1'b1) begin
          fails++; $display("FAIL b2b_read_result: result=%h ready=%b want %h/1", result, cmd_if.cmd_ready, r);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    run_cmd(OP_LOAD, 6'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, "mid_load");
    @(negedge clk);
    drive_cmd(OP_SHR, 6'd8, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    asserts++;
    if (ser_out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_first_shift: valid=%b want 1", ser_out_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_cmd(OP_LOAD, 6'd0, 32'h5555_AAAA, 1'b0, 1'b0);
    @(negedge clk);
    asserts++;
    if (sr_con !== 2'b00 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ser_out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset_idle: sr_con=%b ready=%b busy=%b done=%b valid=%b want 00/1/0/0/0",
                        sr_con, cmd_if.cmd_ready, busy, done, ser_out_valid);
    end
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || sr_con !== 2'b00) begin
      fails++; $display("FAIL reset_beats_valid: busy=%b sr_con=%b want 0/00", busy, sr_con);
    end
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    exp_bits.delete();
    model_val = '0;
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    asserts++;
    if (done_cnt != 0 || result !== 32'h0) begin
      fails++; $display("FAIL mid_no_done: done pulses=%0d result=%h want 0/0", done_cnt, result);
    end
    run_cmd(OP_READ, 6'd0, 32'h0, 1'b0, 1'b0, "mid_read");
  endtask

`ifdef SHIFT_CTRL_ROTATE_EN
  task automatic test_rotate;
    run_cmd(OP_LOAD, 6'd0, 32'h0000_0001, 1'b0, 1'b0, "rot_load");
    run_cmd(OP_SHR, 6'd1, 32'h0, 1'b0, 1'b1, "rot_shr1");
    asserts++;
    if (result !== 32'h8000_0000) begin
      fails++; $display("FAIL rot_const: got %h want 80000000", result);
    end
    run_cmd(OP_SHL, 6'd5, 32'h0, 1'b0, 1'b1, "rot_shl5");
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shr();
    test_shl32();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_CTRL_ROTATE_EN
    test_rotate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
